// File: rtl/boot_rom_arbiter.sv
// ============================================================================
// Module   : boot_rom_arbiter
// Brief    : Shares the single-port boot ROM between instruction fetch and
//            data/debug loads. Default is fixed priority with starvation
//            override; define BOOT_ROM_ARB_RR_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 16
`endif

`default_nettype none

module boot_rom_arbiter #(
    parameter int ADDR_WIDTH = `ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  rom_en_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

    logic instr_req;
    logic data_req;
    logic data_wins;
    logic instr_rvalid_q;
    logic data_rvalid_q;

    // Requests are masked during reset so no grant or ROM access can occur.
    assign instr_req = instr_req_i & ~rst;
    assign data_req  = data_req_i  & ~rst;

`ifdef BOOT_ROM_ARB_RR_EN
    logic last_was_data;

    // On contention the port that was not granted last wins.
    assign data_wins = data_req & (~instr_req | ~last_was_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_was_data <= 1'b1;
        end else if (instr_gnt_o | data_gnt_o) begin
            last_was_data <= data_gnt_o;
        end
    end
`else
    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved   = (starve_cnt == CNT_MAX);
    assign data_wins = data_req & (~instr_req | starved);

    // Counts consecutive denied data cycles; a data grant clears it, so the
    // override lasts exactly one grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (data_gnt_o) begin
            starve_cnt <= '0;
        end else if (data_req && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    assign data_gnt_o  = data_wins;
    assign instr_gnt_o = instr_req & ~data_wins;
    assign rom_en_o    = instr_gnt_o | data_gnt_o;
    assign rom_addr_o  = data_gnt_o ? data_addr_i : instr_addr_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
        end else begin
            instr_rvalid_q <= instr_gnt_o;
            data_rvalid_q  <= data_gnt_o;
        end
    end

    // Gating with rst discards a read whose return lands in a reset cycle.
    assign instr_rvalid_o = instr_rvalid_q & ~rst;
    assign data_rvalid_o  = data_rvalid_q  & ~rst;
    assign instr_rdata_o  = rom_rdata_i;
    assign data_rdata_o   = rom_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_boot_rom_arbiter.sv
// ============================================================================
// Module   : tb_boot_rom_arbiter
// Brief    : Self-checking bench for boot_rom_arbiter with a per-cycle
//            behavioural model and directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_rom_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i;
    logic [AW-1:0] data_addr_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          rom_en_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_rdata_i = '0;

    int checks   = 0;
    int failures = 0;

    boot_rom_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .rom_en_o       (rom_en_o),
        .rom_addr_o     (rom_addr_o),
        .rom_rdata_i    (rom_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] byte_addr);
        return 32'hC0DE_0000 | DW'(byte_addr >> 2);
    endfunction

    // ROM stand-in: data is available the cycle after the enable.
    always @(posedge clk) begin
        if (rom_en_o) rom_rdata_i <= rom_word(rom_addr_o);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: who should win, and what comes back one cycle later.
    int            m_denied    = 0;
    bit            m_last_data = 1'b1;
    bit            m_pend_i    = 1'b0;
    bit            m_pend_d    = 1'b0;
    logic [AW-1:0] m_paddr     = '0;

    always @(negedge clk) begin
        bit            e_ig, e_dg;
        logic [AW-1:0] e_addr;
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (!rst) begin
            if (instr_req_i && data_req_i) begin
`ifdef BOOT_ROM_ARB_RR_EN
                e_dg = !m_last_data;
`else
                e_dg = (m_denied >= SMAX);
`endif
            end else begin
                e_dg = data_req_i;
            end
            e_ig = instr_req_i && !e_dg;
        end
        e_addr = e_dg ? data_addr_i : instr_addr_i;

        chk("m_instr_gnt", 64'(instr_gnt_o), 64'(e_ig));
        chk("m_data_gnt", 64'(data_gnt_o), 64'(e_dg));
        chk("m_rom_en", 64'(rom_en_o), 64'(e_ig | e_dg));
        if (e_ig || e_dg) chk("m_rom_addr", 64'(rom_addr_o), 64'(e_addr));
        chk("m_instr_rvalid", 64'(instr_rvalid_o), 64'(m_pend_i && !rst));
        chk("m_data_rvalid", 64'(data_rvalid_o), 64'(m_pend_d && !rst));
        if (m_pend_i && !rst) chk("m_instr_rdata", 64'(instr_rdata_o), 64'(rom_word(m_paddr)));
        if (m_pend_d && !rst) chk("m_data_rdata", 64'(data_rdata_o), 64'(rom_word(m_paddr)));

        if (rst) begin
            m_denied    = 0;
            m_last_data = 1'b1;
            m_pend_i    = 1'b0;
            m_pend_d    = 1'b0;
        end else begin
            m_pend_i = e_ig;
            m_pend_d = e_dg;
            m_paddr  = e_addr;
            if (e_dg) m_denied = 0;
            else if (data_req_i) m_denied++;
            if (e_ig || e_dg) m_last_data = e_dg;
        end
    end

    // Advance to the next cycle and drive inputs just after the edge.
    task automatic drive(input bit r, input bit ir, input logic [AW-1:0] ia,
                         input bit dr, input logic [AW-1:0] da);
        @(posedge clk);
        #1;
        rst          = r;
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        @(negedge clk);
        #1;
    endtask

    string pat;

    initial begin
        rst = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; data_req_i = 1'b0; data_addr_i = '0;
        for (int i = 0; i < 3; i++) drive(1, 1, 16'h0008, 1, 16'h000C);
        chk("reset_rom_en", 64'(rom_en_o), 64'd0);
        chk("reset_gnts", 64'({instr_gnt_o, data_gnt_o}), 64'd0);

        // Instruction fetches from words 0 and 1.
        drive(0, 1, 16'h0000, 0, 16'h0000);
        chk("if0_gnt", 64'(instr_gnt_o), 64'd1);
        drive(0, 1, 16'h0004, 0, 16'h0000);
        chk("if1_gnt", 64'(instr_gnt_o), 64'd1);
        chk("if0_rdata", 64'(instr_rdata_o), 64'h0000_0000_C0DE_0000);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        chk("if1_rvalid", 64'(instr_rvalid_o), 64'd1);
        chk("if1_rdata", 64'(instr_rdata_o), 64'h0000_0000_C0DE_0001);
        chk("if_no_data_rvalid", 64'(data_rvalid_o), 64'd0);

        // Idle window.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 16'h0000, 0, 16'h0000);
            chk("idle_rom_en", 64'(rom_en_o), 64'd0);
        end

        // Data-only load from 0x10.
        drive(0, 0, 16'h0000, 1, 16'h0010);
        chk("ld_gnt", 64'(data_gnt_o), 64'd1);
        chk("ld_addr", 64'(rom_addr_o), 64'h10);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        chk("ld_rvalid", 64'(data_rvalid_o), 64'd1);
        chk("ld_rdata", 64'(data_rdata_o), 64'h0000_0000_C0DE_0004);
        chk("ld_no_instr_rvalid", 64'(instr_rvalid_o), 64'd0);

        // Continuous contention: record the grant pattern.
        pat = "";
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 16'h0020 + 16'(4 * i), 1, 16'h0030);
            pat = {pat, data_gnt_o ? "D" : (instr_gnt_o ? "I" : "-")};
        end
        drive(0, 0, 16'h0000, 0, 16'h0000);
        checks++;
`ifdef BOOT_ROM_ARB_RR_EN
        if (pat != "IDIDIDIDID") begin
`else
        if (pat != "IIIIDIIIID") begin
`endif
            failures++;
            $display("FAIL contention_pattern actual=%s", pat);
        end

`ifndef BOOT_ROM_ARB_RR_EN
        // Idle cycles must not disturb a partially accumulated starve count.
        drive(0, 1, 16'h0040, 1, 16'h0050);
        drive(0, 1, 16'h0044, 1, 16'h0050);
        for (int i = 0; i < 10; i++) drive(0, 0, 16'h0000, 0, 16'h0000);
        drive(0, 1, 16'h0048, 1, 16'h0050);
        chk("hold_c3_instr", 64'(instr_gnt_o), 64'd1);
        drive(0, 1, 16'h004C, 1, 16'h0050);
        chk("hold_c4_instr", 64'(instr_gnt_o), 64'd1);
        drive(0, 1, 16'h004C, 1, 16'h0050);
        chk("hold_c5_data", 64'(data_gnt_o), 64'd1);
`endif

        // Build up contention, then reset the cycle after a data grant.
        for (int i = 0; i < 3; i++) drive(0, 1, 16'h0060, 1, 16'h0070);
        drive(0, 0, 16'h0000, 1, 16'h0074);
        chk("rst_pre_data_gnt", 64'(data_gnt_o), 64'd1);
        drive(1, 1, 16'h0060, 1, 16'h0070);
        chk("rst_drop_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("rst_no_gnt", 64'({instr_gnt_o, data_gnt_o}), 64'd0);
        drive(0, 1, 16'h0060, 1, 16'h0070);
        chk("rst_after_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("rst_first_instr", 64'(instr_gnt_o), 64'd1);

        // Reset with a non-zero starve count, then contend again.
        for (int i = 0; i < 2; i++) drive(0, 1, 16'h0080, 1, 16'h0090);
        drive(1, 0, 16'h0000, 0, 16'h0000);
        pat = "";
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 16'h00A0, 1, 16'h00B0);
            pat = {pat, data_gnt_o ? "D" : (instr_gnt_o ? "I" : "-")};
        end
        drive(0, 0, 16'h0000, 0, 16'h0000);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        checks++;
`ifdef BOOT_ROM_ARB_RR_EN
        if (pat != "IDIDI") begin
`else
        if (pat != "IIIID") begin
`endif
            failures++;
            $display("FAIL post_reset_pattern actual=%s", pat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
